// File: rtl/score_display.sv
// Score display controller: converts the game score (or the best score while
// waiting) to BCD with a sequential double-dabble engine, tracks the best
// score at game over, and time-multiplexes four active-low 7-segment digits
// with leading-zero blanking and a game-over blink.
module score_display #(
    parameter int SCAN_DIV    = 16250,
    parameter int BLINK_SLOTS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] score,
    input  logic        over,
    input  logic        waiting,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [11:0] best,
    output logic        busy
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(BLINK_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [11:0]   cap_q, cap_d;
    logic [11:0]   sr_q, sr_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   disp_q, disp_d;
    logic [11:0]   best_q, best_d;
    logic          over_q, over_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          phase_q, phase_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic [11:0]   src;
    logic          src_new;
    logic [15:0]   bcd_adj;
    logic [3:0]    zero_from;
    logic          tc;

    assign src     = waiting ? best_q : score;
    assign src_new = (src != cap_q);

    // Per-nibble add-3 correction and per-position leading-zero detection
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        assign zero_from[gi] = (disp_q[15:4*gi] == '0);
    end

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    hex_decode = 7'h40;
            4'd1:    hex_decode = 7'h79;
            4'd2:    hex_decode = 7'h24;
            4'd3:    hex_decode = 7'h30;
            4'd4:    hex_decode = 7'h19;
            4'd5:    hex_decode = 7'h12;
            4'd6:    hex_decode = 7'h02;
            4'd7:    hex_decode = 7'h78;
            4'd8:    hex_decode = 7'h00;
            4'd9:    hex_decode = 7'h10;
            default: hex_decode = 7'h7F;
        endcase
    endfunction

    // Converter state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Converter next-state: capture on change, 12 shift cycles, one commit cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (src_new) state_d = SHIFT;
            SHIFT:   if (cnt_q == 4'd11) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Converter outputs: busy covers the whole conversion including commit
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Conversion datapath: capture, double-dabble step, commit to display
    always_comb begin
        cap_d  = cap_q;
        sr_d   = sr_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        disp_d = disp_q;
        case (state_q)
            IDLE: begin
                if (src_new) begin
                    cap_d = src;
                    sr_d  = src;
                    bcd_d = '0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[14:0], sr_q[11]};
                sr_d  = {sr_q[10:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
            end
            DONE:    disp_d = bcd_q;
            default: ;
        endcase
    end

    // Best score latches on the rising edge of the game-over level
    always_comb begin
        over_d = over;
        best_d = best_q;
        if (over && !over_q && (score > best_q)) best_d = score;
    end

    // Digit scan, blink phase and registered segment/anode drive
    always_comb begin
        tc      = (div_q == DIV_LAST);
        div_d   = tc ? '0 : div_q + 1'b1;
        idx_d   = tc ? idx_q + 2'd1 : idx_q;
        slot_d  = slot_q;
        phase_d = phase_q;
        seg_d   = seg_q;
        an_d    = an_q;
        if (tc) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        if (!over)                             phase_d = 1'b0;
        else if (tc && (slot_q == SLOT_LAST))  phase_d = ~phase_q;
        if (tc) begin
            if ((idx_d != 2'd0) && zero_from[idx_d]) begin
                an_d  = 4'hF;
                seg_d = 8'hFF;
            end else begin
                an_d  = ~(4'd1 << idx_d);
                seg_d = {1'b1, hex_decode(disp_q[{idx_d, 2'b00} +: 4])};
            end
            if (over && phase_d) an_d = 4'hF;
        end
    end

    // Datapath and scan registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q   <= '0;
            sr_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            best_q  <= '0;
            over_q  <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            slot_q  <= '0;
            phase_q <= 1'b0;
            seg_q   <= 8'hFF;
            an_q    <= 4'hF;
        end else begin
            cap_q   <= cap_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            best_q  <= best_d;
            over_q  <= over_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign best = best_q;

endmodule
